// File: rtl/ddr_ui_pkg.sv
// Shared DDR4 MIG user-interface definitions: command codes, widths, address step
// and the write-path state encoding.
package ddr_ui_pkg;

    localparam int UI_ADDR_W = 29;
    localparam int UI_DATA_W = 512;
    localparam int UI_BL_W   = 8;
    localparam int UI_CMD_W  = 3;
    localparam int ADDR_STEP = 8;

    localparam logic [UI_CMD_W-1:0] UI_CMD_WRITE = 3'b000;
    localparam logic [UI_CMD_W-1:0] UI_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } write_state_t;

endpackage

// File: rtl/ui_beat_counter.sv
// Burst beat/command counter: clears on burst load, increments on handshake and
// reports whether the count is still below, or is about to reach, the burst length.
module ui_beat_counter #(
    parameter int BL_W = ddr_ui_pkg::UI_BL_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic [BL_W-1:0] bl,
    output logic [BL_W-1:0] cnt,
    output logic            below,
    output logic            term_nxt
);

    logic [BL_W-1:0] cnt_r;
    logic [BL_W-1:0] cnt_nxt_s;

    // next count value after this cycle's handshake
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (inc) begin
            cnt_nxt_s = cnt_r + BL_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt      = cnt_r;
    assign below    = (cnt_r < bl);
    assign term_nxt = (cnt_nxt_s == bl);

endmodule

// File: rtl/write_module.sv
// DDR4 MIG UI write burst engine: issues one data beat and one write command per
// burst element, data always ahead of command. Optional byte mask: WR_MASK_EN.
module write_module #(
    parameter int ADDR_W    = ddr_ui_pkg::UI_ADDR_W,
    parameter int DATA_W    = ddr_ui_pkg::UI_DATA_W,
    parameter int BL_W      = ddr_ui_pkg::UI_BL_W,
    parameter int ADDR_STEP = ddr_ui_pkg::ADDR_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   wr_cmd_addr,
    input  logic                wr_cmd_start,
    input  logic [BL_W-1:0]     wr_cmd_bl,
    input  logic [2:0]          wr_cmd_intr,
    input  logic [DATA_W-1:0]   data_512bit,
    input  logic                wr_data_valid,
    output logic                wr_data_req,
    output logic                wr_busy,
    output logic                wr_end,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    output logic                app_en,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask
`ifdef WR_MASK_EN
    ,
    input  logic [DATA_W/8-1:0] wr_data_mask,
    output logic                wr_mask_err
`endif
);

    import ddr_ui_pkg::*;

    write_state_t      state_r;
    write_state_t      state_nxt_s;
    logic [BL_W-1:0]   bl_r;
    logic [2:0]        intr_r;
    logic [ADDR_W-1:0] app_addr_r;

    logic              start_ok_s;
    logic              data_acc_s;
    logic              cmd_acc_s;
    logic [BL_W-1:0]   data_cnt_s;
    logic [BL_W-1:0]   cmd_cnt_s;
    logic              data_below_s;
    logic              cmd_below_s;
    logic              data_term_s;
    logic              cmd_term_s;

    assign start_ok_s = (state_r == IDLE) && wr_cmd_start && (wr_cmd_bl != '0);

    ui_beat_counter #(.BL_W(BL_W)) u_data_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s),
        .inc      (data_acc_s),
        .bl       (bl_r),
        .cnt      (data_cnt_s),
        .below    (data_below_s),
        .term_nxt (data_term_s)
    );

    ui_beat_counter #(.BL_W(BL_W)) u_cmd_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s),
        .inc      (cmd_acc_s),
        .bl       (bl_r),
        .cnt      (cmd_cnt_s),
        .below    (cmd_below_s),
        .term_nxt (cmd_term_s)
    );

    // A command only trails an already-accepted beat, keeping the MIG data-first rule.
    assign app_wdf_wren = (state_r == WRITE) && data_below_s && wr_data_valid;
    assign data_acc_s   = app_wdf_wren && app_wdf_rdy;
    assign app_en       = (state_r == WRITE) && cmd_below_s && (cmd_cnt_s < data_cnt_s);
    assign cmd_acc_s    = app_en && app_rdy;

    assign wr_data_req  = data_acc_s;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = data_512bit;
    assign app_addr     = app_addr_r;
    assign app_cmd      = intr_r;
    assign wr_busy      = (state_r != IDLE);
    assign wr_end       = (state_r == DONE);

    // burst sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                if (cmd_term_s && data_term_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // state, burst parameters and command address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            bl_r       <= '0;
            intr_r     <= 3'b000;
            app_addr_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (start_ok_s) begin
                bl_r       <= wr_cmd_bl;
                intr_r     <= wr_cmd_intr;
                app_addr_r <= wr_cmd_addr;
            end else if (cmd_acc_s) begin
                app_addr_r <= app_addr_r + ADDR_W'(ADDR_STEP);
            end else begin
                app_addr_r <= app_addr_r;
            end
        end
    end

`ifdef WR_MASK_EN
    logic mask_err_r;

    // sticky flag for a fully masked beat, cleared when the next burst starts
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_err_r <= 1'b0;
        end else if (start_ok_s) begin
            mask_err_r <= 1'b0;
        end else if (data_acc_s && (&wr_data_mask)) begin
            mask_err_r <= 1'b1;
        end else begin
            mask_err_r <= mask_err_r;
        end
    end

    assign wr_mask_err  = mask_err_r;
    assign app_wdf_mask = wr_data_mask;
`else
    assign app_wdf_mask = '0;
`endif

endmodule

// File: tb/tb_write_module.sv
// Self-checking bench for write_module: randomized handshakes against a queue-based
// model of the expected beats and command addresses.
module tb_write_module;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 512;
    localparam int BL_W   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [ADDR_W-1:0]   wr_cmd_addr;
    logic                wr_cmd_start;
    logic [BL_W-1:0]     wr_cmd_bl;
    logic [2:0]          wr_cmd_intr;
    logic [DATA_W-1:0]   data_512bit;
    logic                wr_data_valid;
    logic                wr_data_req;
    logic                wr_busy;
    logic                wr_end;
    logic                app_rdy;
    logic                app_wdf_rdy;
    logic                app_en;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] fifo_q[$];

    always #5 clk = ~clk;

    write_module #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BL_W(BL_W), .ADDR_STEP(8)) dut (
        .clk(clk), .rst(rst), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_start(wr_cmd_start),
        .wr_cmd_bl(wr_cmd_bl), .wr_cmd_intr(wr_cmd_intr), .data_512bit(data_512bit),
        .wr_data_valid(wr_data_valid), .wr_data_req(wr_data_req), .wr_busy(wr_busy),
        .wr_end(wr_end), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask)
    );

    function automatic logic [DATA_W-1:0] rand512();
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_burst(input string nm, input logic [ADDR_W-1:0] addr, input logic [BL_W-1:0] bl,
                             input logic [2:0] intr, input int p_valid, input int p_rdy, input int p_wdf,
                             input int rdy_mode, input int valid_mode, input int stray_cyc);
        logic [DATA_W-1:0] exp_data[$];
        logic [DATA_W-1:0] got_data[$];
        logic [ADDR_W-1:0] got_addr[$];
        logic [DATA_W-1:0] w;
        logic [ADDR_W-1:0] prev_addr;
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] bad_addr_got;
        logic [ADDR_W-1:0] bad_addr_exp;
        int n_end = 0, end_cyc = -1, inv_errs = 0, cyc = 0, d_acc = 0, c_acc = 0;
        int first_wren = -1, hold = 0, addr_errs = 0, data_errs = 0;
        bit stalled = 1'b0, done = 1'b0, timeout = 1'b0, vgate;
        prev_addr = '0;
        bad_addr_got = '0;
        bad_addr_exp = '0;
        fifo_q.delete();
        for (int i = 0; i < int'(bl) + 3; i++) begin
            w = rand512();
            fifo_q.push_back(w);
            if (i < int'(bl)) exp_data.push_back(w);
        end
        while (!done) begin
            @(negedge clk);
            wr_cmd_start = (cyc == 0) || (cyc == stray_cyc);
            wr_cmd_addr  = (cyc == 0) ? addr : ~addr;
            wr_cmd_bl    = (cyc == 0) ? bl : 8'd5;
            wr_cmd_intr  = (cyc == 0) ? intr : ~intr;
            app_rdy      = (rdy_mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(99) < p_rdy);
            app_wdf_rdy  = ($urandom_range(99) < p_wdf);
            vgate        = ($urandom_range(99) < p_valid);
            if (hold > 0) begin
                vgate = 1'b0;
                hold--;
            end
            wr_data_valid = (fifo_q.size() > 0) && vgate;
            data_512bit   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            #1;
            if (app_wdf_end !== app_wdf_wren) inv_errs++;
            if (app_wdf_mask !== '0) inv_errs++;
            if (app_wdf_data !== data_512bit) inv_errs++;
            if (wr_data_req !== (app_wdf_wren && app_wdf_rdy)) inv_errs++;
            if (app_wdf_wren && !wr_data_valid) inv_errs++;
            if (app_en && (c_acc >= d_acc)) inv_errs++;
            if (stalled && (app_en !== 1'b1 || app_addr !== prev_addr)) inv_errs++;
            if (cyc >= 1 && end_cyc < 0 && wr_busy !== 1'b1) inv_errs++;
            if (end_cyc >= 0 && cyc == end_cyc + 1 && wr_busy !== 1'b0) inv_errs++;
            if (cyc == 0 && (wr_busy !== 1'b0 || app_en !== 1'b0 || app_wdf_wren !== 1'b0)) inv_errs++;
            if (app_wdf_wren && first_wren < 0) first_wren = cyc;
            if (app_wdf_wren && app_wdf_rdy) begin
                got_data.push_back(app_wdf_data);
                d_acc++;
                void'(fifo_q.pop_front());
                if (valid_mode == 1 && d_acc == 1) hold = 5;
            end
            if (app_en && app_rdy) begin
                got_addr.push_back(app_addr);
                c_acc++;
                if (app_cmd !== intr) inv_errs++;
            end
            stalled   = app_en && !app_rdy;
            prev_addr = app_addr;
            if (wr_end) begin
                n_end++;
                if (end_cyc < 0) end_cyc = cyc;
            end
            cyc++;
            if (end_cyc >= 0 && cyc > end_cyc + 1) done = 1'b1;
            if (cyc >= 400) begin
                timeout = 1'b1;
                done    = 1'b1;
            end
        end
        wr_cmd_start = 1'b0;
        for (int i = 0; i < got_addr.size(); i++) begin
            ea = addr + ADDR_W'(i) * 29'd8;
            if (got_addr[i] !== ea) begin
                if (addr_errs == 0) begin
                    bad_addr_got = got_addr[i];
                    bad_addr_exp = ea;
                end
                addr_errs++;
            end
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
            if (got_data[i] !== exp_data[i]) data_errs++;

        tests++;
        if (timeout) begin fails++; $display("FAIL %s timeout: wr_end not seen within 400 cycles (got %0d ends, required 1)", nm, n_end); end
        tests++;
        if (c_acc !== int'(bl)) begin fails++; $display("FAIL %s cmd_count: got %0d required %0d", nm, c_acc, bl); end
        tests++;
        if (d_acc !== int'(bl)) begin fails++; $display("FAIL %s beat_count: got %0d required %0d", nm, d_acc, bl); end
        tests++;
        if (n_end !== 1) begin fails++; $display("FAIL %s wr_end_pulses: got %0d required 1", nm, n_end); end
        tests++;
        if (inv_errs !== 0) begin fails++; $display("FAIL %s protocol_violations: got %0d required 0", nm, inv_errs); end
        tests++;
        if (addr_errs !== 0) begin fails++; $display("FAIL %s cmd_addr: got %h required %h (%0d bad)", nm, bad_addr_got, bad_addr_exp, addr_errs); end
        tests++;
        if (data_errs !== 0) begin fails++; $display("FAIL %s beat_data: got %0d wrong beats required 0", nm, data_errs); end
        if (p_valid == 100 && valid_mode == 0) begin
            tests++;
            if (first_wren !== 1) begin fails++; $display("FAIL %s first_wren_cycle: got %0d required 1", nm, first_wren); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_cmd_start = 1'b0; wr_cmd_addr = 29'h123; wr_cmd_bl = 8'd4; wr_cmd_intr = 3'b000;
        wr_data_valid = 1'b1; data_512bit = rand512(); app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({wr_busy, wr_end, app_en, app_addr, app_cmd, app_wdf_wren, app_wdf_end, wr_data_req, app_wdf_mask} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b end=%b en=%b addr=%h cmd=%b wren=%b req=%b required all 0",
                     wr_busy, wr_end, app_en, app_addr, app_cmd, app_wdf_wren, wr_data_req);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc = 0, errs = 0;
        fifo_q.delete();
        for (int i = 0; i < 4; i++) fifo_q.push_back(rand512());
        for (int c = 0; c < 20 && acc < 1; c++) begin
            @(negedge clk);
            wr_cmd_start = (c == 0); wr_cmd_addr = 29'h200; wr_cmd_bl = 8'd4; wr_cmd_intr = 3'b000;
            app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_data_valid = 1'b1; data_512bit = fifo_q[0];
            #1;
            if (app_wdf_wren && app_wdf_rdy) acc++;
        end
        @(negedge clk);
        wr_cmd_start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({wr_busy, wr_end, app_en, app_addr, app_cmd, app_wdf_wren, app_wdf_end, wr_data_req} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got busy=%b end=%b en=%b addr=%h wren=%b required all 0 (beats before reset %0d)",
                     wr_busy, wr_end, app_en, app_addr, app_wdf_wren, acc);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (wr_end || wr_busy || app_en || app_wdf_wren) errs++;
        end
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL mid_reset_abandon: got %0d active cycles required 0", errs); end
        run_burst("post_reset_bl1", 29'h0A0, 8'd1, 3'b000, 100, 100, 100, 0, 0, -1);
    endtask

    task automatic test_bl_zero();
        int errs = 0;
        @(negedge clk);
        wr_cmd_start = 1'b1; wr_cmd_addr = 29'h40; wr_cmd_bl = 8'd0; wr_cmd_intr = 3'b000;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_data_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (wr_busy || app_en || app_wdf_wren || wr_end) errs++;
            @(negedge clk);
            wr_cmd_start = 1'b0;
        end
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL bl_zero: got %0d active cycles required 0", errs); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [BL_W-1:0]   b;
        logic [2:0]        it;
        for (int k = 0; k < 8; k++) begin
            a  = ADDR_W'($urandom);
            b  = BL_W'($urandom_range(1, 12));
            it = 3'($urandom);
            run_burst($sformatf("random%0d", k), a, b, it, $urandom_range(40, 100),
                      $urandom_range(40, 100), $urandom_range(40, 100), 0, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        run_burst("basic_bl4", 29'h100, 8'd4, 3'b000, 100, 100, 100, 0, 0, -1);
        run_burst("cmd_backpressure", 29'h300, 8'd3, 3'b000, 100, 100, 100, 1, 0, -1);
        run_burst("fifo_empty", 29'h500, 8'd2, 3'b000, 100, 100, 100, 0, 1, -1);
        run_burst("addr_wrap", 29'h1FFFFFF8, 8'd2, 3'b000, 100, 100, 100, 0, 0, 2);
        test_reset_mid();
        test_bl_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_module.md
Name: write_module

Overview:
- Write-side companion to the DDR4 read path: converts one write burst request (start address, beat count) into MIG UI write commands plus write-data beats.
- Pulls 512-bit data from an upstream show-ahead (first-word-fall-through) FIFO.
- Sits between the frame-buffer write arbiter and the DDR4 MIG user interface, in the c0_ddr4_ui_clk domain.
- Signals completion with a one-cycle wr_end pulse.

Parameters:
- ADDR_W, 29, app_addr / wr_cmd_addr width.
- DATA_W, 512, UI data width.
- BL_W, 8, burst-length counter width.
- ADDR_STEP, 8, address increment per accepted command (one 512-bit beat).

Ports:
- clk  in  1  MIG UI clock (c0_ddr4_ui_clk).
- rst  in  1  synchronous reset, active-high.
- wr_cmd_addr  in  ADDR_W  burst start address.
- wr_cmd_start  in  1  one-cycle start pulse.
- wr_cmd_bl  in  BL_W  number of beats/commands in the burst.
- wr_cmd_intr  in  3  UI command code, latched and driven on app_cmd (3'b000 = write).
- data_512bit  in  DATA_W  FIFO head word (show-ahead).
- wr_data_valid  in  1  FIFO not empty.
- wr_data_req  out  1  FIFO pop; high exactly when a beat is accepted by the MIG.
- wr_busy  out  1  burst in progress.
- wr_end  out  1  one-cycle pulse when the burst is complete.
- app_rdy  in  1  MIG command ready.
- app_wdf_rdy  in  1  MIG write-data ready.
- app_en  out  1  command valid.
- app_addr  out  ADDR_W  command address.
- app_cmd  out  3  command code.
- app_wdf_data  out  DATA_W  write data; equals data_512bit.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  last beat of a burst; always equals app_wdf_wren.
- app_wdf_mask  out  DATA_W/8  byte mask; all zeros unless WR_MASK_EN.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - state=IDLE; cmd_cnt, data_cnt, app_addr, bl, intr = 0.
  - All outputs are 0.
  - An in-flight burst is abandoned; no wr_end is generated.
- States:
  - IDLE -> WRITE on wr_cmd_start && wr_cmd_bl!=0. On that edge, latch bl, intr, app_addr<=wr_cmd_addr and clear both counters.
  - wr_cmd_start with wr_cmd_bl==0 is ignored.
  - WRITE -> DONE when both counts equal bl. This includes the cycle in which the final command and final beat are accepted together.
  - DONE -> IDLE unconditionally after one cycle. wr_end=1 only in DONE.
  - wr_cmd_start is ignored in WRITE and DONE.
- wr_busy = (state != IDLE).
- Data path:
  - app_wdf_wren = WRITE && data_cnt<bl && wr_data_valid.
  - A beat is accepted when app_wdf_wren && app_wdf_rdy; on acceptance wr_data_req=1 and data_cnt increments.
  - Data is never issued after data_cnt reaches bl.
- Command path:
  - app_en = WRITE && cmd_cnt<bl && cmd_cnt<data_cnt, using registered counts. A command is therefore issued only after its data beat was accepted, satisfying the MIG data-before-command rule.
  - A command is accepted when app_en && app_rdy; on acceptance cmd_cnt increments and app_addr += ADDR_STEP, modulo 2^ADDR_W (wraps at the address boundary).
  - app_en stays high while app_rdy is low; app_addr is held stable until acceptance.
- Simultaneous events: a data acceptance and a command acceptance in the same cycle update both counters independently.
- Backpressure: wr_data_valid dropping, or app_wdf_rdy/app_rdy low, only stalls; no beat or command is lost or duplicated.
- Latency:
  - First app_wdf_wren is the cycle after start, if the FIFO is non-empty.
  - First app_en is at least one cycle after the first data acceptance.
- Outputs app_en, app_wdf_wren, app_wdf_end and wr_data_req are combinational from registers and inputs. All state is registered.

Optional Feature:
- WR_MASK_EN defined:
  - Adds input port wr_data_mask (DATA_W/8); app_wdf_mask = wr_data_mask, aligned with data_512bit.
  - Adds output wr_mask_err, sticky until the next start: set if an all-ones mask beat is accepted.
- WR_MASK_EN undefined: no extra ports; app_wdf_mask is tied to 0.

Decomposition:
- Shared package ddr_ui_pkg holds:
  - constants UI_CMD_WRITE=3'b000 and UI_CMD_READ=3'b001;
  - ADDR_STEP;
  - the write_state_t enum {IDLE, WRITE, DONE};
  - the UI width constants.
- One natural sub-module: ui_beat_counter (load/clear, increment-on-handshake, terminal compare against bl). It is instantiated twice, for the command and data counts.

Test Plan:
- Start with addr=0x100, bl=4, FIFO full, both readies always 1 -> 4 beats; commands at addresses 0x100, 0x108, 0x110, 0x118; app_cmd=0; exactly 4 wr_data_req; one wr_end pulse; wr_busy falls the cycle after wr_end.
- bl=3, app_rdy toggled 1-0-1-0 -> app_en held with a stable app_addr during app_rdy=0; cmd_cnt never exceeds data_cnt; exactly 3 commands.
- FIFO runs empty after 1 beat for 5 cycles, bl=2 -> app_wdf_wren=0 while empty; second command issued only after the second beat; wr_end once.
- Start with addr=0x1FFFFFF8, bl=2 -> second command address wraps to 0x0000000; wr_cmd_start during WRITE is ignored.
- rst asserted mid-burst (after 1 of 4 beats) -> all outputs 0 the next cycle, no wr_end; a new start with bl=1 then completes normally.
- Start with bl=0 -> no app_en, no app_wdf_wren, wr_busy stays 0.
